// File: rtl/alu_pkg.sv
// Shared ALU types: function encoding and the packed result record used by
// the ALU bench, decode logic and the streaming execution stage.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_RSVD = 3'b011,
        OP_ANDN = 3'b100,
        OP_ORN  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [ALU_W-1:0] y;
        logic             zero;
        logic             carry_out;
        logic             overflow;
        logic             illegal;
    } alu_result_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, add/sub through one shared adder (f[2]
// inverts b and injects the +1), and signed set-less-than.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum;
    logic             ovf_add;
    alu_op_e          op;

    assign op      = alu_op_e'(f);
    assign b_sel   = f[2] ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, f[2]};
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf_add = (a[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y         = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ANDN: y = a & ~b;
            OP_ORN:  y = a | ~b;
            OP_ADD, OP_SUB: begin
                y         = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = ovf_add;
            end
            OP_SLT: begin
                y         = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_add};
                carry_out = sum[WIDTH];
                overflow  = ovf_add;
            end
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_stream_stage.sv
// Valid/ready execution stage around the ALU with a two-entry result queue
// and a delivered-results counter; in_ready depends on registered state only.
module alu_stream_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal,
    output logic [31:0]      result_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] y_mem    [DEPTH];
    logic [3:0]       flag_mem [DEPTH];  // {zero, carry_out, overflow, illegal}

    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_ovf;
    logic [WIDTH-1:0] new_y;
    logic [3:0]       new_flags;
    logic             is_rsvd;
    logic             push;
    logic             pop;

    alu #(.WIDTH(WIDTH)) u_alu (
        .f         (f),
        .a         (a),
        .b         (b),
        .y         (alu_y),
        .zero      (alu_zero),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    assign is_rsvd   = (alu_op_e'(f) == OP_RSVD);
    assign new_y     = is_rsvd ? '0 : alu_y;
    assign new_flags = is_rsvd ? 4'b1001 : {alu_zero, alu_carry, alu_ovf, 1'b0};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= EMPTY;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            result_count <= 32'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr       <= ~rd_ptr;
                result_count <= result_count + 32'd1;
            end
            case (state)
                EMPTY:   if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= FULL;
                    else if (!push && pop) state <= EMPTY;
                end
                FULL:    if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Queue storage is data only; validity comes from state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            y_mem[wr_ptr]    <= new_y;
            flag_mem[wr_ptr] <= new_flags;
        end
    end

    assign y         = out_valid ? y_mem[rd_ptr] : '0;
    assign zero      = out_valid && flag_mem[rd_ptr][3];
    assign carry_out = out_valid && flag_mem[rd_ptr][2];
    assign overflow  = out_valid && flag_mem[rd_ptr][1];
    assign illegal   = out_valid && flag_mem[rd_ptr][0];

endmodule
